// File: rtl/loom_mem_port_arb.sv
// loom_mem_port_arb
// Shares one single-port SRAM (1-cycle read latency) between the DUT functional
// port and the scan controller read port. DUT has priority while Shared, but a
// scan request denied MaxWait cycles in a row is forced through. A scan session
// (scan_lock_i) drains any in-flight read and then owns the SRAM exclusively.
// Read data is routed back to whichever port issued the read.
//
// Optional feature: define LOOM_MEM_ARB_STATS_EN to add conflict_cnt_o, a
// saturating count of Shared-state cycles in which both ports requested.
//
// Handshake: a request is accepted in the same cycle its *_gnt_o is high
// (combinational grant); the request must be held until granted. Read data
// comes back exactly one cycle after the grant, qualified by *_rvalid_o.
// dbg_state_o exposes the FSM state (0=Shared, 1=Drain, 2=Locked).

module loom_mem_port_arb #(
    parameter int AddrWidth = 4,
    parameter int DataWidth = 8,
    parameter int MaxWait   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 dut_req_i,
    input  logic                 dut_we_i,
    input  logic [AddrWidth-1:0] dut_addr_i,
    input  logic [DataWidth-1:0] dut_wdata_i,
    output logic                 dut_gnt_o,
    output logic                 dut_rvalid_o,
    output logic [DataWidth-1:0] dut_rdata_o,
    input  logic                 scan_req_i,
    input  logic [AddrWidth-1:0] scan_addr_i,
    output logic                 scan_gnt_o,
    output logic                 scan_rvalid_o,
    output logic [DataWidth-1:0] scan_rdata_o,
    input  logic                 scan_lock_i,
    output logic                 lock_ack_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    input  logic [DataWidth-1:0] mem_rdata_i,
`ifdef LOOM_MEM_ARB_STATS_EN
    output logic [15:0]          conflict_cnt_o,
`endif
    output logic [1:0]           dbg_state_o
);

    localparam logic [1:0] ST_SHARED = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic OWNER_DUT  = 1'b0;
    localparam logic OWNER_SCAN = 1'b1;

    localparam int            CntW     = $clog2(MaxWait + 1);
    localparam logic [CntW-1:0] WaitMax = CntW'(MaxWait);

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            rd_pend_q;
    logic            owner_q;
    logic            dut_gnt, scan_gnt;
    logic            wait_at_max;

    assign wait_at_max = (wait_cnt_q == WaitMax);

    // Grant selection; nothing is granted while reset is asserted or in the
    // cycle a lock request is first seen in Shared.
    always_comb begin
        dut_gnt  = 1'b0;
        scan_gnt = 1'b0;
        if (rst_ni) begin
            case (state_q)
                ST_SHARED: begin
                    if (!scan_lock_i) begin
                        scan_gnt = scan_req_i && (!dut_req_i || wait_at_max);
                        dut_gnt  = dut_req_i && !scan_gnt;
                    end
                end
                ST_LOCKED: scan_gnt = scan_req_i;
                default: ;
            endcase
        end
    end

    // Next-state logic: Shared -> Drain/Locked on lock, Drain -> Locked, Locked -> Shared on unlock.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SHARED: if (scan_lock_i) state_d = rd_pend_q ? ST_DRAIN : ST_LOCKED;
            ST_DRAIN:  state_d = ST_LOCKED;
            ST_LOCKED: if (!scan_lock_i) state_d = ST_SHARED;
            default:   state_d = ST_SHARED;
        endcase
    end

    // Starvation counter: tracks consecutive denied scan cycles in Shared, saturating.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == ST_SHARED && scan_req_i && !scan_gnt) begin
            wait_cnt_d = wait_at_max ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
    end

    // FSM, starvation counter and read-return tracking registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_SHARED;
            wait_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            owner_q    <= OWNER_DUT;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rd_pend_q  <= (dut_gnt && !dut_we_i) || scan_gnt;
            if (scan_gnt) begin
                owner_q <= OWNER_SCAN;
            end else if (dut_gnt) begin
                owner_q <= OWNER_DUT;
            end
        end
    end

`ifdef LOOM_MEM_ARB_STATS_EN
    logic        lock_q;
    logic [15:0] conflict_cnt_q;

    // Contention statistics; restart at the beginning of every scan session.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q         <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            lock_q <= scan_lock_i;
            if (scan_lock_i && !lock_q) begin
                conflict_cnt_q <= '0;
            end else if (dut_req_i && scan_req_i && state_q == ST_SHARED &&
                         conflict_cnt_q != 16'hFFFF) begin
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
            end
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
`endif

    assign dut_gnt_o   = dut_gnt;
    assign scan_gnt_o  = scan_gnt;
    assign mem_req_o   = dut_gnt | scan_gnt;
    assign mem_we_o    = dut_gnt & dut_we_i;
    assign mem_addr_o  = dut_gnt ? dut_addr_i : (scan_gnt ? scan_addr_i : '0);
    assign mem_wdata_o = dut_gnt ? dut_wdata_i : '0;

    assign dut_rvalid_o  = rd_pend_q && (owner_q == OWNER_DUT);
    assign scan_rvalid_o = rd_pend_q && (owner_q == OWNER_SCAN);
    assign dut_rdata_o   = rst_ni ? mem_rdata_i : '0;
    assign scan_rdata_o  = rst_ni ? mem_rdata_i : '0;

    assign lock_ack_o  = (state_q == ST_LOCKED);
    assign dbg_state_o = state_q;

endmodule
